// File: rtl/uart_tx_sched_if.sv
// Requester-side byte bus for uart_tx_sched: one valid/ready pair and one byte lane per requester.
interface uart_tx_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// Multi-requester UART transmitter: round-robin byte arbitration with optional per-line
// grant locking, 8 data bits LSB first, optional even parity, one stop bit.
module uart_tx_sched #(
    parameter int NREQ      = 4,
    parameter int LINE_LOCK = 1,
    parameter int MAX_LINE  = 255,
    parameter int LOCK_TO   = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             cfg_div,
    input  logic                    cfg_parity_en,
    uart_tx_sched_if.slave          req,
    output logic                    tx,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    lock_active
);
    localparam int GW = $clog2(NREQ);
    localparam int LW = $clog2(MAX_LINE + 1);
    localparam int TW = $clog2(LOCK_TO + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q;
    logic            tx_q, busy_q, par_q;
    logic [15:0]     cnt_q, div_q;
    logic [2:0]      bit_q;
    logic [7:0]      sh_q;
    logic [GW-1:0]   grant_q;
    logic            lock_q, lock_d;
    logic [LW-1:0]   line_q, line_d, line_inc;
    logic [TW-1:0]   to_q, to_d;

    logic [GW-1:0]   win, cand;
    logic            win_vld, accept;
    logic [7:0]      acc_byte;

    // Winner search walks backwards so the closest requester after grant_q is assigned last.
    always_comb begin
        win     = grant_q;
        win_vld = 1'b0;
        cand    = grant_q;
        if (lock_q) begin
            win_vld = req.req_valid[grant_q];
        end else begin
            for (int k = NREQ; k >= 1; k--) begin
                cand = GW'((int'(grant_q) + k) % NREQ);
                if (req.req_valid[cand]) begin
                    win     = cand;
                    win_vld = 1'b1;
                end
            end
        end
        accept        = rst_n && (state_q == IDLE) && win_vld;
        req.req_ready = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
        acc_byte      = req.req_data[{win, 3'b000} +: 8];
    end

    // Line lock bookkeeping: a clear always beats a set in the same cycle.
    always_comb begin
        lock_d   = lock_q;
        line_d   = line_q;
        to_d     = to_q;
        line_inc = line_q + LW'(1);
        if (accept) begin
            to_d = '0;
            if (LINE_LOCK == 0 || acc_byte == 8'h0A || line_inc == LW'(MAX_LINE)) begin
                lock_d = 1'b0;
                line_d = '0;
            end else begin
                lock_d = 1'b1;
                line_d = line_inc;
            end
        end else if (state_q == IDLE && lock_q && !req.req_valid[grant_q]) begin
            if (to_q + TW'(1) >= TW'(LOCK_TO)) begin
                to_d   = TW'(LOCK_TO);
                lock_d = 1'b0;
                line_d = '0;
            end else begin
                to_d = to_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            grant_q <= GW'(NREQ - 1);
            lock_q  <= 1'b0;
            line_q  <= '0;
            to_q    <= '0;
        end else begin
            lock_q <= lock_d;
            line_q <= line_d;
            to_q   <= to_d;
            if (state_q != IDLE && cnt_q != 16'd0)
                cnt_q <= cnt_q - 16'd1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= cfg_div;
                        div_q   <= cfg_div;
                        par_q   <= cfg_parity_en;
                        sh_q    <= acc_byte;
                        grant_q <= win;
                    end
                end
                START: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= DATA;
                        tx_q    <= sh_q[0];
                        bit_q   <= 3'd0;
                        cnt_q   <= div_q;
                    end
                end
                DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= div_q;
                        if (bit_q == 3'd7) begin
                            state_q <= par_q ? PARITY : STOP;
                            tx_q    <= par_q ? ^sh_q : 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= sh_q[bit_q + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                        cnt_q   <= div_q;
                    end
                end
                STOP: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign lock_active = lock_q;
endmodule
